ex_stage: RTL

//  Execute stage, directly downstream of the ID/EX pipeline register.
//  - Consumes the decoded instruction and produces the registered EX result for the EX/MEM register.
//  - Single-cycle ALU, address generation and link write-back.
//  - Shifts run on an iterative shifter that stalls the front end.
//  - Opcode/category codes are the `IC_*/`INS_* macros from defines.v.

---
 rtl/ex_stage.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU, address generation and link write-back, plus an
// iterative shifter that stalls the front end. Define SHIFT_BY4_EN for 4-bit shift steps.

`ifndef IC_EMP
`define IC_EMP   3'd0
`define IC_ARI   3'd1
`define IC_LOAD  3'd2
`define IC_STORE 3'd3
`define IC_JUMP  3'd4
`endif

`ifndef INS_EMP
`define INS_EMP  5'd0
`define INS_ADD  5'd1
`define INS_SUB  5'd2
`define INS_SLT  5'd3
`define INS_SLTU 5'd4
`define INS_AND  5'd5
`define INS_OR   5'd6
`define INS_XOR  5'd7
`define INS_LUI  5'd8
`define INS_SLL  5'd9
`define INS_SRL  5'd10
`define INS_SRA  5'd11
`define INS_LW   5'd12
`define INS_SW   5'd13
`define INS_JAL  5'd14
`endif

module ex_stage #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    input  logic [2:0]      inst_catagory,
    input  logic [4:0]      local_opcode,
    input  logic [XLEN-1:0] ari_op1,
    input  logic [XLEN-1:0] ari_op2,
    input  logic            we_in,
    input  logic [31:0]     w_addr_in,
    input  logic [31:0]     link_addr,
    input  logic [31:0]     offset,
    input  logic            busy_in,
    input  logic            mem_stall,
    output logic            stall_req,
    output logic [2:0]      out_catagory,
    output logic [4:0]      out_opcode,
    output logic            we_out,
    output logic [4:0]      w_addr_out,
    output logic [XLEN-1:0] w_data,
    output logic [31:0]     mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic            busy_out
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]    acc_q, acc_d;
    logic [4:0]         sh_op_q, sh_op_d;
    logic [4:0]         sh_dest_q, sh_dest_d;
    logic               sh_we_q, sh_we_d;

    logic [2:0]         out_catagory_q, out_catagory_d;
    logic [4:0]         out_opcode_q, out_opcode_d;
    logic               we_out_q, we_out_d;
    logic [4:0]         w_addr_out_q, w_addr_out_d;
    logic [XLEN-1:0]    w_data_q, w_data_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]    mem_wdata_q, mem_wdata_d;
    logic               busy_out_q, busy_out_d;

    logic [SHAMT_W-1:0] shamt, step, cnt_rem;
    logic               is_shift;
    logic [XLEN-1:0]    alu_res, acc_next;
    logic               unused_w_addr;

    assign shamt         = ari_op2[SHAMT_W-1:0];
    assign is_shift      = (inst_catagory == `IC_ARI) &&
                           (local_opcode == `INS_SLL || local_opcode == `INS_SRL ||
                            local_opcode == `INS_SRA);
    assign unused_w_addr = ^w_addr_in[31:5];

`ifdef SHIFT_BY4_EN
    assign step = (cnt_q >= SHAMT_W'(4)) ? SHAMT_W'(4) : SHAMT_W'(1);
`else
    assign step = SHAMT_W'(1);
`endif
    assign cnt_rem = cnt_q - step;

    always_comb begin
        case (sh_op_q)
            `INS_SLL: acc_next = acc_q << step;
            `INS_SRL: acc_next = acc_q >> step;
            default:  acc_next = $signed(acc_q) >>> step;
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (local_opcode)
            `INS_ADD:  alu_res = ari_op1 + ari_op2;
            `INS_SUB:  alu_res = ari_op1 - ari_op2;
            `INS_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(ari_op1) < $signed(ari_op2)};
            `INS_SLTU: alu_res = {{(XLEN-1){1'b0}}, ari_op1 < ari_op2};
            `INS_AND:  alu_res = ari_op1 & ari_op2;
            `INS_OR:   alu_res = ari_op1 | ari_op2;
            `INS_XOR:  alu_res = ari_op1 ^ ari_op2;
            `INS_LUI:  alu_res = ari_op2;
            `INS_SLL, `INS_SRL, `INS_SRA: alu_res = ari_op1;
            default:   alu_res = '0;
        endcase
    end

    // While shifting, release the front end in the cycle whose step finishes the shift.
    always_comb begin
        if (state_q == ST_SHIFT) begin
            stall_req = (cnt_rem != '0);
        end else begin
            stall_req = is_shift && (shamt != '0) && !busy_in;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        acc_d          = acc_q;
        sh_op_d        = sh_op_q;
        sh_dest_d      = sh_dest_q;
        sh_we_d        = sh_we_q;
        out_catagory_d = out_catagory_q;
        out_opcode_d   = out_opcode_q;
        we_out_d       = we_out_q;
        w_addr_out_d   = w_addr_out_q;
        w_data_d       = w_data_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        busy_out_d     = busy_out_q;

        if (busy_in) begin
            state_d        = ST_IDLE;
            cnt_d          = '0;
            out_catagory_d = `IC_EMP;
            out_opcode_d   = `INS_EMP;
            we_out_d       = 1'b0;
            w_addr_out_d   = '0;
            w_data_d       = '0;
            mem_addr_d     = '0;
            mem_wdata_d    = '0;
            busy_out_d     = 1'b1;
        end else if (!mem_stall && rdy_in) begin
            out_catagory_d = `IC_EMP;
            out_opcode_d   = `INS_EMP;
            we_out_d       = 1'b0;
            w_addr_out_d   = '0;
            w_data_d       = '0;
            mem_addr_d     = '0;
            mem_wdata_d    = '0;
            busy_out_d     = 1'b0;
            if (state_q == ST_SHIFT) begin
                acc_d = acc_next;
                cnt_d = cnt_rem;
                if (cnt_rem == '0) begin
                    state_d        = ST_IDLE;
                    out_catagory_d = `IC_ARI;
                    out_opcode_d   = sh_op_q;
                    we_out_d       = sh_we_q;
                    w_addr_out_d   = sh_dest_q;
                    w_data_d       = acc_next;
                end
            end else if (is_shift && (shamt != '0)) begin
                state_d   = ST_SHIFT;
                acc_d     = ari_op1;
                cnt_d     = shamt;
                sh_op_d   = local_opcode;
                sh_dest_d = w_addr_in[4:0];
                sh_we_d   = we_in;
            end else if (inst_catagory inside {`IC_ARI, `IC_LOAD, `IC_STORE, `IC_JUMP}) begin
                out_catagory_d = inst_catagory;
                out_opcode_d   = local_opcode;
                we_out_d       = we_in;
                w_addr_out_d   = w_addr_in[4:0];
                case (inst_catagory)
                    `IC_ARI:  w_data_d = alu_res;
                    `IC_JUMP: w_data_d = link_addr;
                    default: begin
                        mem_addr_d  = ari_op1 + offset;
                        mem_wdata_d = ari_op2;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            acc_q          <= '0;
            sh_op_q        <= '0;
            sh_dest_q      <= '0;
            sh_we_q        <= 1'b0;
            out_catagory_q <= `IC_EMP;
            out_opcode_q   <= `INS_EMP;
            we_out_q       <= 1'b0;
            w_addr_out_q   <= '0;
            w_data_q       <= '0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            busy_out_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            acc_q          <= acc_d;
            sh_op_q        <= sh_op_d;
            sh_dest_q      <= sh_dest_d;
            sh_we_q        <= sh_we_d;
            out_catagory_q <= out_catagory_d;
            out_opcode_q   <= out_opcode_d;
            we_out_q       <= we_out_d;
            w_addr_out_q   <= w_addr_out_d;
            w_data_q       <= w_data_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            busy_out_q     <= busy_out_d;
        end
    end

    assign out_catagory = out_catagory_q;
    assign out_opcode   = out_opcode_q;
    assign we_out       = we_out_q;
    assign w_addr_out   = w_addr_out_q;
    assign w_data       = w_data_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign busy_out     = busy_out_q;

endmodule
